// File: rtl/mem_request_master.sv
// mem_request_master
//
// Turns a single-beat load/store request into a memory bus transaction.
// The transaction always runs IDLE -> SETUP -> STROBE -> WAIT -> DONE.
// A request that is badly formed goes straight from IDLE to DONE with an
// error, and in that case the memory is never touched.
//
// Request handshake: req is sampled only while the block is idle (busy=0).
// On the edge that samples it, the request is accepted and all req_* fields
// are captured. busy rises in the following cycle and stays high through the
// single-cycle done pulse. While busy is high, req is ignored; requests are
// not queued. A new request can be accepted in the first idle cycle after
// done.
//
// Memory handshake: mem_enable rises one cycle after the bus fields are set
// up and stays high until mem_moc is seen in WAIT, or until the WAIT budget
// of TIMEOUT cycles runs out.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   req, req_write,         request strobe, 1=store / 0=load,
//   req_size, req_signed    0=byte 1=half 2=word 3=invalid, sign-extend loads
//   req_addr, req_wdata     byte address, right-justified store data
//   busy, done              transaction in flight, one-cycle completion
//   rdata, err, err_code    extended load result, error flag, error code
//                           (00 ok, 01 misaligned, 10 timeout, 11 bad size)
//   mem_enable, mem_rw      memory strobe, 1=read / 0=write
//   mem_addr, mem_wdata,    memory bus fields
//   mem_mode
//   mem_moc, mem_rdata      memory operation complete, read data
//   fsm_state               current controller state, for observation

module mem_request_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [8:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_mode,
    input  logic        mem_moc,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        cap_signed;
    logic        misaligned;

    assign fsm_state  = state;
    assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    // Right-justified read data extended to 32 bits according to the
    // access size that was captured into mem_mode.
    function automatic logic [31:0] extend(input logic [1:0] mode,
                                           input logic sgn,
                                           input logic [31:0] d);
        logic [31:0] r;
        case (mode)
            2'd0:    r = sgn ? {{24{d[7]}}, d[7:0]}   : {24'b0, d[7:0]};
            2'd1:    r = sgn ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 8'd0;
            cap_signed <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            mem_enable <= 1'b0;
            mem_rw     <= 1'b1;
            mem_addr   <= 9'd0;
            mem_wdata  <= 32'd0;
            mem_mode   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cap_signed <= req_signed;
                        busy       <= 1'b1;
                        if (req_size == 2'd3) begin
                            // Invalid size wins over misalignment.
                            state    <= S_DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end else if (misaligned) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            // Bus fields change only for requests that will
                            // actually reach the memory.
                            state     <= S_SETUP;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                            mem_mode  <= req_size;
                            mem_rw    <= ~req_write;
                        end
                    end
                end
                S_SETUP: begin
                    state      <= S_STROBE;
                    mem_enable <= 1'b1;
                end
                S_STROBE: begin
                    // The first WAIT cycle counts as cycle 1.
                    state    <= S_WAIT;
                    wait_cnt <= 8'd1;
                end
                S_WAIT: begin
                    if (mem_moc) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        mem_enable <= 1'b0;
                        err        <= 1'b0;
                        err_code   <= 2'b00;
                        if (mem_rw) begin
                            rdata <= extend(mem_mode, cap_signed, mem_rdata);
                        end
                    end else if (wait_cnt == 8'(TIMEOUT)) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        mem_enable <= 1'b0;
                        err        <= 1'b1;
                        err_code   <= 2'b10;
                        rdata      <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    wait_cnt <= 8'd0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_master.sv
// Bench for mem_request_master.
//
// Each request is described at transaction level: the driver works out from
// the request fields and the memory response delay which edge the done
// pulse must follow, which cycles must show busy and mem_enable, what the
// bus fields must read and what the completion result must be. A compare
// process checks every cycle against those expectations, and completions
// are matched against an expected queue.
//
// Cycle numbering: cyc counts rising edges; "cycle cyc" is the interval
// after edge cyc. A request accepted on edge n shows busy from cycle n.

module tb_mem_request_master;

    localparam int TIMEOUT = 16;
    localparam int W = 35;   // {err, err_code, rdata}

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_code;
    logic        mem_enable;
    logic        mem_rw;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_mode;
    logic        mem_moc;
    logic [31:0] mem_rdata;
    logic [2:0]  fsm_state;

    mem_request_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .err_code   (err_code),
        .mem_enable (mem_enable),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mode   (mem_mode),
        .mem_moc    (mem_moc),
        .mem_rdata  (mem_rdata),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- expectations ----------------
    int          checks = 0;
    int          errors = 0;
    bit          chk_on = 1'b0;
    int          exp_n = 0;        // busy window [exp_n, exp_d]
    int          exp_d = -5;       // done cycle
    int          exp_en_lo = 1;    // mem_enable window
    int          exp_en_hi = 0;
    logic [31:0] exp_rdata = 32'd0;
    logic [8:0]  exp_addr  = 9'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [1:0]  exp_mode  = 2'd0;
    logic        exp_rw    = 1'b1;
    logic [W-1:0] exp_q[$];

    int          acc_n = 0;
    int          last_done_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] d);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = d % 32'd256;
            if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = d % 32'd65536;
            if (sg && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("done", {63'd0, done}, {63'd0, (cyc == exp_d)});
            chk("busy", {63'd0, busy}, {63'd0, (cyc >= exp_n && cyc <= exp_d)});
            chk("mem_enable", {63'd0, mem_enable}, {63'd0, (cyc >= exp_en_lo && cyc <= exp_en_hi)});
            chk("rdata", {32'd0, rdata}, {32'd0, exp_rdata});
            chk("mem_addr", {55'd0, mem_addr}, {55'd0, exp_addr});
            chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_wdata});
            chk("mem_mode", {62'd0, mem_mode}, {62'd0, exp_mode});
            chk("mem_rw", {63'd0, mem_rw}, {63'd0, exp_rw});
            if (done) begin
                logic [W-1:0] e;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {29'd0, err, err_code, rdata}, {29'd0, e});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge with the DUT idle. moc_w is the WAIT
    // cycle index (0 = first) in which mem_moc is presented; negative means
    // never. stale raises mem_moc during SETUP.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [8:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                          input int moc_w, input bit hold, input bit stale);
        int          n;
        int          d;
        bit          bad;
        logic [1:0]  code;
        logic [31:0] res;
        req = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd; mem_rdata = rd;
        n = cyc + 1;
        acc_n = n;
        bad = 1'b0;
        code = 2'b00;
        if (sz == 2'd3) begin
            bad = 1'b1; code = 2'b11;
        end else if ((sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0)) begin
            bad = 1'b1; code = 2'b01;
        end
        res = exp_rdata;
        if (bad) begin
            d = n;
        end else if (moc_w >= 0 && moc_w < TIMEOUT) begin
            d = n + 3 + moc_w;
            if (!wr) res = load_value(sz, sg, rd);
        end else begin
            d = n + 2 + TIMEOUT;
            code = 2'b10;
            res = 32'd0;
        end
        exp_n = n;
        exp_d = d;
        if (bad) begin
            exp_en_lo = 1; exp_en_hi = 0;
        end else begin
            exp_en_lo = n + 1; exp_en_hi = d - 1;
        end
        exp_q.push_back({(code != 2'b00), code, res});
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        mem_moc = stale;
        if (!bad) begin
            exp_addr = ad; exp_wdata = wd; exp_mode = sz; exp_rw = ~wr;
        end
        while (cyc < d) begin
            @(posedge clk); #1;
            mem_moc = (moc_w >= 0 && cyc == n + 2 + moc_w);
        end
        exp_rdata = res;
        @(posedge clk); #1;
        mem_moc = 1'b0;
    endtask

    // Word load that is cut short by reset two cycles into WAIT, with req
    // also high during the reset edge.
    task automatic do_abort();
        int n;
        req = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 9'h010; req_wdata = 32'h0; mem_rdata = 32'h12345678;
        n = cyc + 1;
        acc_n = n;
        exp_n = n; exp_d = n + 2 + TIMEOUT;
        exp_en_lo = n + 1; exp_en_hi = exp_d - 1;
        @(posedge clk); #1;
        req = 1'b0;
        exp_addr = 9'h010; exp_wdata = 32'h0; exp_mode = 2'd2; exp_rw = 1'b1;
        while (cyc < n + 3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req = 1'b0;
        exp_n = 0; exp_d = -5; exp_en_lo = 1; exp_en_hi = 0;
        exp_rdata = 32'd0;
        exp_addr = 9'd0; exp_wdata = 32'd0; exp_mode = 2'd0; exp_rw = 1'b1;
        @(negedge clk);
        chk("abort_enable_low", {63'd0, mem_enable}, 64'd0);
        chk("abort_busy_low", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; req = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 9'd0; req_wdata = 32'd0; mem_moc = 1'b0; mem_rdata = 32'd0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_mem_rw", {63'd0, mem_rw}, 64'd1);
        chk("reset_err_code", {62'd0, err_code}, 64'd0);
        chk("reset_rdata", {32'd0, rdata}, 64'd0);

        // Word store, memory completes in the second WAIT cycle.
        do_req(1'b1, 2'd2, 1'b0, 9'h008, 32'hDEADBEEF, 32'h0, 1, 1'b0, 1'b0);
        chk("store_latency", 64'(last_done_cyc - acc_n), 64'd4);

        // Byte loads: fastest completion, done in the 4th cycle after the
        // accepting edge.
        do_req(1'b0, 2'd0, 1'b1, 9'h005, 32'h0, 32'h000000F0, 0, 1'b0, 1'b0);
        chk("byte_signed_value", {32'd0, rdata}, 64'hFFFFFFF0);
        chk("fast_latency", 64'(last_done_cyc - acc_n), 64'd3);
        do_req(1'b0, 2'd0, 1'b0, 9'h005, 32'h0, 32'h000000F0, 0, 1'b0, 1'b0);
        chk("byte_unsigned_value", {32'd0, rdata}, 64'h000000F0);

        // Misaligned half and invalid size (also misaligned).
        do_req(1'b0, 2'd1, 1'b0, 9'h003, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        chk("misaligned_code", {62'd0, err_code}, 64'd1);
        chk("error_latency", 64'(last_done_cyc - acc_n), 64'd0);
        do_req(1'b0, 2'd3, 1'b0, 9'h001, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        chk("invalid_code", {62'd0, err_code}, 64'd3);

        // Timeout: memory never answers.
        do_req(1'b0, 2'd2, 1'b0, 9'h00C, 32'h0, 32'h55555555, -1, 1'b0, 1'b0);
        chk("timeout_code", {62'd0, err_code}, 64'd2);
        chk("timeout_rdata", {32'd0, rdata}, 64'd0);
        chk("timeout_latency", 64'(last_done_cyc - acc_n), 64'(TIMEOUT + 2));

        // Reset mid-WAIT, then a normal byte load.
        do_abort();
        do_req(1'b0, 2'd0, 1'b0, 9'h00A, 32'h0, 32'h12345681, 0, 1'b0, 1'b0);
        chk("post_reset_value", {32'd0, rdata}, 64'h00000081);

        // req held across two transactions; stale moc during second SETUP.
        do_req(1'b1, 2'd1, 1'b0, 9'h004, 32'hAAAA5555, 32'h0, 0, 1'b1, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 9'h00C, 32'h0, 32'hCAFEF00D, 2, 1'b0, 1'b1);
        chk("held_second_value", {32'd0, rdata}, 64'hCAFEF00D);

        // Memory answers in the very last WAIT cycle.
        do_req(1'b0, 2'd2, 1'b0, 9'h1FC, 32'h0, 32'h80000000, TIMEOUT - 1, 1'b0, 1'b0);
        chk("last_wait_value", {32'd0, rdata}, 64'h80000000);

        // Signed halfword load.
        do_req(1'b0, 2'd1, 1'b1, 9'h002, 32'h0, 32'h00018000, 0, 1'b0, 1'b0);
        chk("half_signed_value", {32'd0, rdata}, 64'hFFFF8000);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_completions", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
